sumsub_dr_ctrl: RTL and testbench
=================================

// Module: sumsub_dr_ctrl
// PURPOSE
//  Synchronous front/back end for the dual-rail SumSub datapath. Accepts single-rail operands
//  over a valid/ready handshake and encodes them dual-rail (t/f per bit, RTZ 4-phase protocol).
//  Detects completion on the dual-rail result and decodes it back to single-rail on an output
//  valid/ready handshake. Sits between the clocked ULA control logic and the clockless adder.
// PARAMETERS
//  WIDTH        10   operand/result width in bits
//  SYNC_STAGES  2    flops per rail in the result synchronizer (>=2)
//  TIMEOUT      255  max cycles waited in DATA or NULL phase before flagging error (8-bit counter)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat (IDLE only)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_op      in   1      0 = A+B, 1 = A-B
//  in_cin     in   1      carry/borrow in
//  dr_a_t/f   out  WIDTH  dual-rail A to datapath
//  dr_b_t/f   out  WIDTH  dual-rail B to datapath
//  dr_op_t/f  out  1      dual-rail op
//  dr_cin_t/f out  1      dual-rail carry in
//  dr_res_t/f in   WIDTH  dual-rail result from datapath (asynchronous)
//  dr_cout_t/f in  1      dual-rail carry out (asynchronous)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  out_res    out  WIDTH  decoded result
//  out_cout   out  1      decoded carry out
//  out_err    out  1      beat is erroneous (timeout or illegal 11 code); qualified by out_valid
// BEHAVIOUR
//  - Reset: state IDLE; all dr_* outputs 0 (NULL); in_ready=1; out_valid=0; out_res=0; out_cout=0;
//    out_err=0; synchronizer flops and timeout counter 0. Reset mid-operation returns datapath to NULL.
//  - Encoding: bit x -> (t,f) = (x,~x); NULL = (0,0). All dr_* driven from flops (glitch-free).
//  - Every dual-rail input rail passes an SYNC_STAGES flop synchronizer before any decision.
//  - COMPLETE = every result/cout bit has exactly one rail high in two consecutive synced samples
//    with identical value. EMPTY = all synced rails 0. ILLEGAL = any bit with both rails high.
//  - FSM: IDLE --in_valid--> DATA (operands registered and driven this edge, counter cleared).
//    DATA --COMPLETE--> HOLD: out_res/out_cout latched, out_valid=1, out_err=0.
//    DATA --ILLEGAL or counter==TIMEOUT--> HOLD with out_err=1, out_res=0.
//    HOLD --out_ready--> NULL: all dr_* driven 0, out_valid=0 next cycle.
//    NULL --EMPTY--> IDLE; NULL --counter==TIMEOUT--> IDLE with sticky err flag set, reported as
//    out_err=1 on the next result beat.
//  - Operands are never changed while DATA/HOLD; inputs are ignored when in_ready=0.
//  - Min latency in_valid accept -> out_valid: SYNC_STAGES+2 cycles after datapath settles.
//  - out_* stable while out_valid=1 and out_ready=0. No back-to-back beats: in_ready=0 until IDLE.
//  - Arithmetic is the datapath's (mod 2^WIDTH); this block only encodes/decodes, no math.
// STRUCTURE
//  - Package sumsub_dr_pkg: state enum {IDLE,DATA,HOLD,NUL}, DR_NULL constant, function
//    dr_enc(x) and dr_dec(t,f), TIMEOUT width constant.
//  - One sub-module: dr_sync_cmp (rail synchronizer + COMPLETE/EMPTY/ILLEGAL detector).
// TESTING (bench models datapath as dual-rail adder with random 1-20 cycle async delay)
//  - A=5,B=3,op=0,cin=0 -> dr_a_t=0x005,dr_a_f=0x3FA; out_res=8,out_cout=0,out_err=0.
//  - A=0x3FF,B=1,op=0,cin=0 -> out_res=0,out_cout=1; then NULL phase, in_ready=1 after EMPTY.
//  - A=3,B=5,op=1,cin=1 -> out_res=0x3FE; hold out_ready=0 10 cycles: out_* unchanged.
//  - Model drives res bit 4 both rails high -> out_valid with out_err=1,out_res=0.
//  - Model never completes -> out_err=1 after 255 cycles in DATA; block still returns to IDLE.
//  - rst_n low during DATA -> all dr_* 0 and out_valid=0 asynchronously; next beat correct.

Source files
------------

// File: rtl/sumsub_dr_pkg.sv
// Shared types and dual-rail helpers for the SumSub dual-rail front/back end.
package sumsub_dr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    HOLD = 2'd2,
    NUL  = 2'd3
  } state_t;

  localparam int TO_W = 8;
  localparam logic [1:0] DR_NULL = 2'b00;

  // {t,f} for one bit; NULL is both rails low
  function automatic logic [1:0] dr_enc(input logic x);
    return {x, ~x};
  endfunction

  function automatic logic dr_dec(input logic t, input logic f);
    return t & ~f;
  endfunction

endpackage

// File: rtl/sumsub_dr_ctrl_sync_cmp.sv
// Synchronizes the asynchronous dual-rail result rails and classifies the
// synced word as COMPLETE, EMPTY or ILLEGAL.
module dr_sync_cmp
  import sumsub_dr_pkg::*;
#(
  parameter int N           = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_t,
  input  logic [N-1:0] i_f,
  output logic [N-1:0] o_t,
  output logic [N-1:0] o_f,
  output logic         o_complete,
  output logic         o_empty,
  output logic         o_illegal
);

  logic [N-1:0] r_t [SYNC_STAGES];
  logic [N-1:0] r_f [SYNC_STAGES];
  logic [N-1:0] r_prev_t;
  logic [N-1:0] r_prev_f;
  logic [N-1:0] w_t;
  logic [N-1:0] w_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_t[s] <= '0;
        r_f[s] <= '0;
      end
      r_prev_t <= '0;
      r_prev_f <= '0;
    end else begin
      r_t[0] <= i_t;
      r_f[0] <= i_f;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_t[s] <= r_t[s-1];
        r_f[s] <= r_f[s-1];
      end
      r_prev_t <= w_t;
      r_prev_f <= w_f;
    end
  end

  assign w_t = r_t[SYNC_STAGES-1];
  assign w_f = r_f[SYNC_STAGES-1];

  // a word seen fully valid and unchanged over two samples cannot still be settling
  assign o_complete = (&(w_t ^ w_f)) && (w_t == r_prev_t) && (w_f == r_prev_f);
  assign o_empty    = ~|(w_t | w_f);
  assign o_illegal  = |(w_t & w_f);
  assign o_t        = w_t;
  assign o_f        = w_f;

endmodule

// File: rtl/sumsub_dr_ctrl.sv
// Clocked front/back end for the clockless dual-rail SumSub datapath:
// encodes operands onto RTZ dual-rail, waits for completion, decodes the result.
module sumsub_dr_ctrl
  import sumsub_dr_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_cin,
  output logic [WIDTH-1:0] dr_a_t,
  output logic [WIDTH-1:0] dr_a_f,
  output logic [WIDTH-1:0] dr_b_t,
  output logic [WIDTH-1:0] dr_b_f,
  output logic             dr_op_t,
  output logic             dr_op_f,
  output logic             dr_cin_t,
  output logic             dr_cin_f,
  input  logic [WIDTH-1:0] dr_res_t,
  input  logic [WIDTH-1:0] dr_res_f,
  input  logic             dr_cout_t,
  input  logic             dr_cout_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_err
);

  localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_res;
  logic             r_out_cout;
  logic             r_out_err;
  logic             r_sticky_err;
  logic [TO_W-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a_t, r_a_f, r_b_t, r_b_f;
  logic             r_op_t, r_op_f, r_cin_t, r_cin_f;

  logic [WIDTH:0]   w_sync_t;
  logic [WIDTH:0]   w_sync_f;
  logic [WIDTH:0]   w_dec;
  logic             w_complete;
  logic             w_empty;
  logic             w_illegal;

  dr_sync_cmp #(
    .N           (WIDTH + 1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_t        ({dr_cout_t, dr_res_t}),
    .i_f        ({dr_cout_f, dr_res_f}),
    .o_t        (w_sync_t),
    .o_f        (w_sync_f),
    .o_complete (w_complete),
    .o_empty    (w_empty),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < WIDTH + 1; i++) w_dec[i] = dr_dec(w_sync_t[i], w_sync_f[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_res    <= '0;
      r_out_cout   <= 1'b0;
      r_out_err    <= 1'b0;
      r_sticky_err <= 1'b0;
      r_cnt        <= '0;
      r_a_t        <= '0;
      r_a_f        <= '0;
      r_b_t        <= '0;
      r_b_f        <= '0;
      {r_op_t, r_op_f}   <= DR_NULL;
      {r_cin_t, r_cin_f} <= DR_NULL;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
              {r_a_t[i], r_a_f[i]} <= dr_enc(in_a[i]);
              {r_b_t[i], r_b_f[i]} <= dr_enc(in_b[i]);
            end
            {r_op_t, r_op_f}   <= dr_enc(in_op);
            {r_cin_t, r_cin_f} <= dr_enc(in_cin);
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (w_complete) begin
            r_out_res    <= w_dec[WIDTH-1:0];
            r_out_cout   <= w_dec[WIDTH];
            r_out_err    <= r_sticky_err;
            r_sticky_err <= 1'b0;
            r_out_valid  <= 1'b1;
            r_state      <= HOLD;
          end else if (w_illegal || (r_cnt == TO_VAL)) begin
            r_out_res    <= '0;
            r_out_cout   <= 1'b0;
            r_out_err    <= 1'b1;
            r_sticky_err <= 1'b0;
            r_out_valid  <= 1'b1;
            r_state      <= HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_a_t       <= '0;
            r_a_f       <= '0;
            r_b_t       <= '0;
            r_b_f       <= '0;
            {r_op_t, r_op_f}   <= DR_NULL;
            {r_cin_t, r_cin_f} <= DR_NULL;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= NUL;
          end
        end
        NUL: begin
          if (w_empty) begin
            r_in_ready <= 1'b1;
            r_state    <= IDLE;
          end else if (r_cnt == TO_VAL) begin
            // datapath never returned to NULL; flag it on the next result beat
            r_sticky_err <= 1'b1;
            r_in_ready   <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_cout  = r_out_cout;
  assign out_err   = r_out_err;
  assign dr_a_t    = r_a_t;
  assign dr_a_f    = r_a_f;
  assign dr_b_t    = r_b_t;
  assign dr_b_f    = r_b_f;
  assign dr_op_t   = r_op_t;
  assign dr_op_f   = r_op_f;
  assign dr_cin_t  = r_cin_t;
  assign dr_cin_f  = r_cin_f;

endmodule

// File: tb/tb_sumsub_dr_ctrl.sv
// Bench for sumsub_dr_ctrl: dual-rail adder model with random async delay,
// protocol scoreboard checked every cycle, plus directed literal expectations.
module tb_sumsub_dr_ctrl;

  localparam int W = 10;
  localparam int M_NORMAL  = 0;
  localparam int M_ILLEGAL = 1;
  localparam int M_NEVER   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_op = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_cout, out_err;
  logic [W-1:0] out_res;
  logic [W-1:0] dr_a_t, dr_a_f, dr_b_t, dr_b_f;
  logic         dr_op_t, dr_op_f, dr_cin_t, dr_cin_f;
  logic [W-1:0] dr_res_t = '0, dr_res_f = '0;
  logic         dr_cout_t = 1'b0, dr_cout_f = 1'b0;

  sumsub_dr_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_cin(in_cin),
    .dr_a_t(dr_a_t), .dr_a_f(dr_a_f), .dr_b_t(dr_b_t), .dr_b_f(dr_b_f),
    .dr_op_t(dr_op_t), .dr_op_f(dr_op_f), .dr_cin_t(dr_cin_t), .dr_cin_f(dr_cin_f),
    .dr_res_t(dr_res_t), .dr_res_f(dr_res_f), .dr_cout_t(dr_cout_t), .dr_cout_f(dr_cout_f),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_cout(out_cout), .out_err(out_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // A+B+cin or A+~B+cin, mod 2^W with carry out in bit W
  function automatic logic [W:0] sumsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic op, input logic cin);
    logic [W:0] bb;
    bb = {1'b0, (op ? ~b : b)};
    return {1'b0, a} + bb + {{W{1'b0}}, cin};
  endfunction

  // ---------------- clockless datapath model ----------------
  int   mode = M_NORMAL;
  logic ops_valid, ops_null;
  assign ops_valid = (&(dr_a_t ^ dr_a_f)) && (&(dr_b_t ^ dr_b_f)) &&
                     (dr_op_t ^ dr_op_f) && (dr_cin_t ^ dr_cin_f);
  assign ops_null  = ~|{dr_a_t, dr_a_f, dr_b_t, dr_b_f, dr_op_t, dr_op_f, dr_cin_t, dr_cin_f};

  initial begin
    logic [W:0] r;
    int dly;
    forever begin
      wait (ops_valid);
      dly = $urandom_range(20, 1) * 10 + 3;
      #(dly);
      if (ops_valid && mode != M_NEVER) begin
        r = sumsub(dr_a_t, dr_b_t, dr_op_t, dr_cin_t);
        dr_res_t  = r[W-1:0];
        dr_res_f  = ~r[W-1:0];
        dr_cout_t = r[W];
        dr_cout_f = ~r[W];
        if (mode == M_ILLEGAL) begin
          dr_res_t[4] = 1'b1;
          dr_res_f[4] = 1'b1;
        end
      end
      wait (ops_null);
      dly = $urandom_range(20, 1) * 10 + 3;
      #(dly);
      dr_res_t = '0; dr_res_f = '0; dr_cout_t = 1'b0; dr_cout_f = 1'b0;
    end
  end

  // ---------------- protocol model / scoreboard ----------------
  logic         exp_drv = 1'b0, exp_op = 1'b0, exp_cin = 1'b0;
  logic [W-1:0] exp_a = '0, exp_b = '0;
  logic         pend = 1'b0;
  logic [W-1:0] exp_res = '0;
  logic         exp_cout = 1'b0, exp_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_drv = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        exp_drv = 1'b0;
        pend    = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_drv = 1'b1;
        exp_a = in_a; exp_b = in_b; exp_op = in_op; exp_cin = in_cin;
      end
    end
  end

  logic         pv = 1'b0, pr = 1'b0, pcout = 1'b0, perr = 1'b0;
  logic [W-1:0] pres = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_dr_null", 64'({dr_a_t, dr_a_f, dr_b_t, dr_b_f, dr_op_t, dr_op_f, dr_cin_t, dr_cin_f}), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      pv = 1'b0;
    end else begin
      chk("dr_operands",
          64'({dr_a_t, dr_a_f, dr_b_t, dr_b_f, dr_op_t, dr_op_f, dr_cin_t, dr_cin_f}),
          exp_drv ? 64'({exp_a, ~exp_a, exp_b, ~exp_b, exp_op, ~exp_op, exp_cin, ~exp_cin}) : 64'd0);
      if (exp_drv) chk("in_ready_busy", 64'(in_ready), 64'd0);
      if (!pend) chk("no_beat_valid", 64'(out_valid), 64'd0);
      if (pend && out_valid)
        chk("out_beat", 64'({out_res, out_cout, out_err}), 64'({exp_res, exp_cout, exp_err}));
      if (pv && !pr) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_stable", 64'({out_res, out_cout, out_err}), 64'({pres, pcout, perr}));
      end
      pv = out_valid; pr = out_ready; pres = out_res; pcout = out_cout; perr = out_err;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                      input logic cin, input int md, input int hold,
                      output logic [W-1:0] res, output logic cout, output logic err,
                      output int lat, output logic [W-1:0] at, output logic [W-1:0] af);
    logic [W:0] s;
    logic acc, got, rdy;
    s = sumsub(a, b, op, cin);
    mode     = md;
    exp_res  = (md == M_NORMAL) ? s[W-1:0] : '0;
    exp_cout = (md == M_NORMAL) ? s[W] : 1'b0;
    exp_err  = (md != M_NORMAL);
    pend     = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(posedge clk);
      acc = in_ready;
    end
    chk("accept", 64'(acc), 64'd1);
    #2;
    at = dr_a_t; af = dr_a_f;
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_op = 1'($urandom); in_cin = 1'($urandom);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      got = out_valid;
    end
    chk("out_valid_seen", 64'(got), 64'd1);
    res = out_res; cout = out_cout; err = out_err;
    repeat (hold) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 400 && !rdy; i++) begin
      @(posedge clk); #1;
      rdy = in_ready;
    end
    chk("back_to_idle", 64'(rdy), 64'd1);
  endtask

  initial begin
    logic [W-1:0] res, at, af;
    logic cout, err;
    int lat;

    #1;
    chk("reset_out_res", 64'({out_res, out_cout, out_err}), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    beat(10'd5, 10'd3, 1'b0, 1'b0, M_NORMAL, 0, res, cout, err, lat, at, af);
    chk("b1_dr_a_t", 64'(at), 64'h005);
    chk("b1_dr_a_f", 64'(af), 64'h3FA);
    chk("b1_result", 64'({res, cout, err}), 64'({10'd8, 1'b0, 1'b0}));
    chk("b1_latency", 64'(lat >= 5 && lat <= 24), 64'd1);

    beat(10'h3FF, 10'd1, 1'b0, 1'b0, M_NORMAL, 0, res, cout, err, lat, at, af);
    chk("b2_result", 64'({res, cout, err}), 64'({10'd0, 1'b1, 1'b0}));

    beat(10'd3, 10'd5, 1'b1, 1'b1, M_NORMAL, 10, res, cout, err, lat, at, af);
    chk("b3_result", 64'({res, cout, err}), 64'({10'h3FE, 1'b0, 1'b0}));

    beat(10'h2AA, 10'h055, 1'b0, 1'b0, M_ILLEGAL, 2, res, cout, err, lat, at, af);
    chk("b4_illegal", 64'({res, err}), 64'({10'd0, 1'b1}));

    beat(10'd7, 10'd9, 1'b0, 1'b0, M_NEVER, 0, res, cout, err, lat, at, af);
    chk("b5_timeout", 64'({res, err}), 64'({10'd0, 1'b1}));
    chk("b5_timeout_cycles", 64'(lat >= 255 && lat <= 257), 64'd1);

    // reset while the datapath is in its DATA phase
    mode = M_NEVER;
    @(posedge clk); #2;
    in_valid = 1'b1; in_a = 10'h155; in_b = 10'h0AA; in_op = 1'b0; in_cin = 1'b1;
    @(posedge clk); #2 in_valid = 1'b0;
    chk("rst_pre_dr_a_t", 64'(dr_a_t), 64'h155);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_dr", 64'({dr_a_t, dr_a_f, dr_b_t, dr_b_f, dr_op_t, dr_op_f, dr_cin_t, dr_cin_f}), 64'd0);
    chk("rst_async_valid", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    #20 rst_n = 1'b1;

    beat(10'd100, 10'd27, 1'b0, 1'b1, M_NORMAL, 3, res, cout, err, lat, at, af);
    chk("b6_after_reset", 64'({res, cout, err}), 64'({10'd128, 1'b0, 1'b0}));

    beat(10'h200, 10'h300, 1'b1, 1'b0, M_NORMAL, 1, res, cout, err, lat, at, af);
    chk("b7_sub", 64'({res, cout, err}), 64'({10'h2FF, 1'b0, 1'b0}));

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
